// File: rtl/frame_mem_slave.sv
// Wishbone classic word slave over an on-chip frame buffer: programmable wait
// states, big-endian byte-select writes, error termination outside the window.
module frame_mem_slave #(
  parameter int          MEM_WORDS   = 76800,
  parameter logic [21:0] BASE_ADR    = 22'h008000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [3:0]  sel_i,
  input  logic [21:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int          IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [22:0] LIMIT   = {1'b0, BASE_ADR} + 23'(4 * MEM_WORDS);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        dat_q, dat_d;
  logic               we_q;
  logic [3:0]         sel_q;
  logic [31:0]        wdat_q;
  logic [IDX_W-1:0]   idx_q;
  logic               oor_q;
  logic               wr_en;
  logic               req;
  logic               oor;
  logic [21:0]        off;
  logic [31:0]        mem_q [MEM_WORDS];

  assign req = cyc_i && stb_i;
  assign off = adr_i - BASE_ADR;
  // Range is judged on the raw byte address; the index is only trusted when in range.
  assign oor = (adr_i < BASE_ADR) || ({1'b0, adr_i} >= LIMIT) || (adr_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (state_q == S_IDLE && req) begin
      we_q   <= we_i;
      sel_q  <= sel_i;
      wdat_q <= dat_i;
      idx_q  <= IDX_W'(off >> 2);
      oor_q  <= oor;
    end
  end

  // sel bit b covers dat[8b+7:8b]; sel[3] is the lowest-addressed byte.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem_q[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (!cyc_i) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ack_d = 1'b0;
    err_d = 1'b0;
    dat_d = dat_q;
    wr_en = 1'b0;
    if (state_q == S_RESP) begin
      if (oor_q) begin
        err_d = 1'b1;
        dat_d = 32'd0;
      end else begin
        ack_d = 1'b1;
        if (we_q) wr_en = 1'b1;
        else      dat_d = mem_q[idx_q];
      end
    end
  end

  assign ack_o  = ack_q;
  assign err_o  = err_q;
  assign dat_o  = dat_q;
  assign busy_o = (state_q != S_IDLE);

endmodule
